// File: rtl/fixmul_pipe.sv
// rtl/fixmul_pipe.sv - pipelined signed fixed-point multiplier with rounding, saturation and handshake
module fixmul_pipe #(
  parameter int WIDTH    = 19,
  parameter int FRAC     = 18,
  parameter int LATENCY  = 3,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = PW + 1;
  localparam logic [FRAC-1:0] HALF = FRAC'(1) << (FRAC - 1);

  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [RW-1:0] rnd_t;

  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] res;
  } out_t;

  // Rounding works one bit wider than the product so the half-LSB increment never wraps.
  function automatic rnd_t round_fn(input prod_t p);
    rnd_t pe;
    rnd_t r;
    pe = rnd_t'(p);
    if (ROUND == 0) begin
      r = pe >>> FRAC;
    end else begin
      r = (pe + (rnd_t'(1) <<< (FRAC - 1))) >>> FRAC;
      // A half-up tie landed on an odd value; the even neighbour is one below.
      if (ROUND == 2 && p[FRAC-1:0] == HALF && r[0]) begin
        r = r - rnd_t'(1);
      end
    end
    return r;
  endfunction

  // In range exactly when all bits from the result sign bit upward agree.
  function automatic out_t clamp_fn(input rnd_t r);
    out_t             o;
    logic [RW-WIDTH:0] hi;
    hi    = r[RW-1:WIDTH-1];
    o.ovf = !((&hi) || !(|hi));
    o.res = r[WIDTH-1:0];
    if (SATURATE != 0 && o.ovf) begin
      o.res = r[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return o;
  endfunction

  logic             adv;
  logic             vld   [1:LATENCY];
  logic [TAG_W-1:0] tag_q [1:LATENCY];
  out_t             out_q;
  prod_t            mul_in;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign in_ready = !vld[LATENCY] || out_ready;
  assign adv      = in_ready;
  assign mul_in   = prod_t'($signed(in_a)) * prod_t'($signed(in_b));

  // Valid bits and tags travel together through every stage, bubbles included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= LATENCY; i++) begin
        vld[i]   <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (adv) begin
      vld[1]   <= in_valid;
      tag_q[1] <= in_tag;
      for (int i = 2; i <= LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_lat1
    // Multiply, round and clamp all land in the single output register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q <= '0;
      end else if (adv) begin
        out_q <= clamp_fn(round_fn(mul_in));
      end
    end
  end else if (LATENCY == 2) begin : g_lat2
    prod_t p1;
    // Stage 1 multiplies; stage 2 rounds and clamps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p1    <= '0;
        out_q <= '0;
      end else if (adv) begin
        p1    <= mul_in;
        out_q <= clamp_fn(round_fn(p1));
      end
    end
  end else begin : g_latn
    prod_t p1;
    rnd_t  r_q [2:LATENCY-1];
    // Stage 1 multiplies, stage 2 rounds, middle stages delay, last stage clamps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p1    <= '0;
        out_q <= '0;
        for (int i = 2; i <= LATENCY - 1; i++) begin
          r_q[i] <= '0;
        end
      end else if (adv) begin
        p1     <= mul_in;
        r_q[2] <= round_fn(p1);
        for (int i = 3; i <= LATENCY - 1; i++) begin
          r_q[i] <= r_q[i-1];
        end
        out_q <= clamp_fn(r_q[LATENCY-1]);
      end
    end
  end

  assign out_valid  = vld[LATENCY];
  assign out_tag    = tag_q[LATENCY];
  assign out_result = out_q.res;
  assign out_ovf    = out_q.ovf;

endmodule

// File: tb/tb_fixmul_pipe.sv
// tb/tb_fixmul_pipe.sv - self-checking bench for fixmul_pipe across all rounding and overflow modes
module tb_fixmul_pipe;

  localparam int W  = 19;
  localparam int F  = 18;
  localparam int L  = 3;
  localparam int TW = 4;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b0;

  logic          ir   [N];
  logic          ov   [N];
  logic          of   [N];
  logic [W-1:0]  res  [N];
  logic [TW-1:0] otag [N];

  always #5 clk = ~clk;

  // Instances 0..2: ROUND 0/1/2 with saturation; instance 3: ROUND 1 with wrap.
  for (genvar g = 0; g < N; g++) begin : g_dut
    fixmul_pipe #(
      .WIDTH(W), .FRAC(F), .LATENCY(L),
      .ROUND((g == 3) ? 1 : g), .SATURATE((g == 3) ? 0 : 1), .TAG_W(TW)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(ir[g]),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_result(res[g]), .out_tag(otag[g]), .out_ovf(of[g])
    );
  end

  typedef struct packed {
    logic [TW-1:0]         tag;
    logic [N-1:0][W-1:0]   res;
    logic [N-1:0]          ovf;
    int                    acc;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pops = 0;
  bit            lat_chk = 0;
  bit            stalled = 0;
  bit            last_acc = 0;
  bit            popped = 0;
  logic [W-1:0]  p_res  [N];
  logic          p_of   [N];
  logic [TW-1:0] p_tag  [N];
  logic [W-1:0]  pop_res [N];
  logic          pop_of  [N];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask

  // Reference: exact integer product, floor division, then the rounding rule on the remainder.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tg);
    exp_t   e;
    longint p, one, half, q, rem, maxv, minv;
    p    = longint'($signed(a)) * longint'($signed(b));
    one  = longint'(1) << F;
    half = one / 2;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    e     = '0;
    e.tag = tg;
    for (int g = 0; g < N; g++) begin
      int mode;
      bit sat;
      mode = (g == 3) ? 1 : g;
      sat  = (g != 3);
      q = p / one;
      if (p < 0 && (p % one) != 0) q = q - 1;
      rem = p - q * one;
      if (mode == 1 && rem >= half) q = q + 1;
      if (mode == 2 && (rem > half || (rem == half && (q % 2) != 0))) q = q + 1;
      e.ovf[g] = (q > maxv) || (q < minv);
      if (e.ovf[g] && sat) e.res[g] = (q > maxv) ? 19'h3FFFF : 19'h40000;
      else                 e.res[g] = q[W-1:0];
    end
    return e;
  endfunction

  // One clock: drive at the falling edge, check outputs, record any input transfer.
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tg, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    cyc++;
    popped = 0;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("in_ready[%0d]", g), 64'(ir[g]), 64'(!ov[g] || ordy));
      if (stalled) begin
        chk($sformatf("hold_valid[%0d]", g), 64'(ov[g]), 64'(1));
        chk($sformatf("hold_res[%0d]", g), 64'(res[g]), 64'(p_res[g]));
        chk($sformatf("hold_ovf[%0d]", g), 64'(of[g]), 64'(p_of[g]));
        chk($sformatf("hold_tag[%0d]", g), 64'(otag[g]), 64'(p_tag[g]));
      end
    end
    if (sb.size() == 0) begin
      for (int g = 0; g < N; g++) chk($sformatf("idle_valid[%0d]", g), 64'(ov[g]), 64'(0));
    end else if (ov[0] && ordy) begin
      e = sb.pop_front();
      pops++;
      popped = 1;
      for (int g = 0; g < N; g++) begin
        chk($sformatf("valid[%0d]", g), 64'(ov[g]), 64'(1));
        chk($sformatf("result[%0d]", g), 64'(res[g]), 64'(e.res[g]));
        chk($sformatf("ovf[%0d]", g), 64'(of[g]), 64'(e.ovf[g]));
        chk($sformatf("tag[%0d]", g), 64'(otag[g]), 64'(e.tag));
        pop_res[g] = res[g];
        pop_of[g]  = of[g];
      end
      if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(L));
    end
    stalled = ov[0] && !ordy;
    for (int g = 0; g < N; g++) begin
      p_res[g] = res[g];
      p_of[g]  = of[g];
      p_tag[g] = otag[g];
    end
    last_acc = v && ir[0];
    if (last_acc) begin
      e     = model(a, b, tg);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tg, input logic [N-1:0][W-1:0] er,
                          input logic [N-1:0] eo);
    bit got;
    got = 0;
    step(1'b1, a, b, tg, 1'b1);
    for (int t = 0; t < 20 && !got; t++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      got = popped;
    end
    chk({nm, "_seen"}, 64'(got), 64'(1));
    if (got) begin
      for (int g = 0; g < N; g++) begin
        chk($sformatf("%s_res[%0d]", nm, g), 64'(pop_res[g]), 64'(er[g]));
        chk($sformatf("%s_ovf[%0d]", nm, g), 64'(pop_of[g]), 64'(eo[g]));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_valid[%0d]", g), 64'(ov[g]), 64'(0));
      chk($sformatf("rst_res[%0d]", g), 64'(res[g]), 64'(0));
      chk($sformatf("rst_tag[%0d]", g), 64'(otag[g]), 64'(0));
      chk($sformatf("rst_ovf[%0d]", g), 64'(of[g]), 64'(0));
    end
    sb.delete();
    stalled = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'(1));
  endtask

  logic [W-1:0] bp_a [10];
  logic [W-1:0] bp_b [10];
  int           sent;

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    step(1'b0, '0, '0, '0, 1'b1);

    lat_chk = 1;
    directed("basic", 19'h20000, 19'h20000, 4'h5,
             {19'h10000, 19'h10000, 19'h10000, 19'h10000}, 4'b0000);
    directed("negneg", 19'h40000, 19'h40000, 4'h6,
             {19'h40000, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF}, 4'b1111);
    directed("tie1", 19'h00001, 19'h20000, 4'h7,
             {19'h00001, 19'h00000, 19'h00001, 19'h00000}, 4'b0000);
    directed("tie3", 19'h00003, 19'h20000, 4'h8,
             {19'h00002, 19'h00002, 19'h00002, 19'h00001}, 4'b0000);
    directed("tieneg", 19'h7FFFF, 19'h20000, 4'h9,
             {19'h00000, 19'h00000, 19'h00000, 19'h7FFFF}, 4'b0000);

    // Back-pressure: ten tagged products, random out_ready, source holds until accepted.
    lat_chk = 0;
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
    end
    bp_a[3] = 19'h40000;
    bp_b[3] = 19'h40000;
    sent = 0;
    pops = 0;
    for (int t = 0; t < 300 && (sent < 10 || sb.size() > 0); t++) begin
      step(sent < 10, (sent < 10) ? bp_a[sent] : '0, (sent < 10) ? bp_b[sent] : '0,
           TW'(sent), 1'($urandom_range(0, 1)));
      if (last_acc) sent++;
    end
    chk("bp_count", 64'(pops), 64'(10));

    // Reset with three products in flight: nothing may emerge afterwards.
    step(1'b1, 19'h20000, 19'h20000, 4'h1, 1'b0);
    step(1'b1, 19'h10000, 19'h30000, 4'h2, 1'b0);
    step(1'b1, 19'h3FFFF, 19'h3FFFF, 4'h3, 1'b0);
    do_reset();
    for (int t = 0; t < 6; t++) step(1'b0, '0, '0, '0, 1'b1);
    lat_chk = 1;
    directed("post_rst", 19'h30000, 19'h20000, 4'hA,
             {19'h18000, 19'h18000, 19'h18000, 19'h18000}, 4'b0000);

    // Full rate: a new operand pair every cycle, downstream always ready.
    pops = 0;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 19'h40000 : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 19'h40000 : W'($urandom);
      step(1'b1, a, b, TW'(i), 1'b1);
      chk("full_rate_accept", 64'(last_acc), 64'(1));
    end
    for (int t = 0; t < 10; t++) step(1'b0, '0, '0, '0, 1'b1);
    chk("full_rate_count", 64'(pops), 64'(100));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
